// File: rtl/fwd_hazard_ctrl.sv
// EX forwarding selects and load-use stall/bubble over a DEPTH-deep shadow pipe; selects/bubble registered (1 cycle), stall combinational.
// No handshake: stall is the only backpressure. HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt outputs.
module fwd_hazard_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_reg_wr,
  input  logic              id_mem_rd,
  input  logic [ADDR_W-1:0] id_wr_addr,
  input  logic              ex_flush,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              stall,
  output logic              bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              ld;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  // Only entries that can still be forwarded from are kept; the oldest
  // stage has no consumer and simply falls off.
  entry_t           pipe_q [DEPTH];
  entry_t           ex_entry;
  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             late_a, late_b;
  logic             hazard;
  logic             kill;

  function automatic logic is_writer(input entry_t e);
    return e.valid && e.wr && (e.addr != '0);
  endfunction

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    late_a = 1'b0;
    late_b = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (is_writer(pipe_q[j]) && (pipe_q[j].addr == id_rs)) begin
        sel_a  = SEL_W'(j + 1);
        late_a = pipe_q[j].ld && ((j + 1) < LOAD_READY);
      end
      if (is_writer(pipe_q[j]) && (pipe_q[j].addr == id_rt)) begin
        sel_b  = SEL_W'(j + 1);
        late_b = pipe_q[j].ld && ((j + 1) < LOAD_READY);
      end
    end
  end

  always_comb begin
    hazard = id_valid && (late_a || late_b);
    stall  = rst_n && hazard && !ex_flush;
    kill   = ex_flush || stall;
    ex_entry = '0;
    if (!kill) begin
      ex_entry.valid = id_valid;
      ex_entry.wr    = id_reg_wr;
      ex_entry.ld    = id_mem_rd;
      ex_entry.addr  = id_wr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
      fwd_a  <= '0;
      fwd_b  <= '0;
      bubble <= 1'b0;
    end else begin
      pipe_q[0] <= ex_entry;
      for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
      fwd_a  <= kill ? '0 : sel_a;
      fwd_b  <= kill ? '0 : sel_b;
      bubble <= kill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (stall)  state_nxt = ST_STALL;
      ST_STALL: if (!stall) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
    if (ex_flush) state_nxt = ST_RUN;
  end

  // A stall edge always leaves a NOP in EX.
  always_ff @(posedge clk) begin
    if (rst_n && (state == ST_STALL)) assert (bubble && !pipe_q[0].valid);
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF))    stall_cnt <= stall_cnt + 16'd1;
      if (ex_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomised + directed bench for fwd_hazard_ctrl: two configurations (2/2 and 3/3) share one ID stream,
// a history-of-EX-occupants model predicts each cycle, and a negedge monitor pops and compares.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0, id_reg_wr = 1'b0, id_mem_rd = 1'b0, ex_flush = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wr_addr = '0;
  logic [1:0] fa0, fb0, fa1, fb1;
  logic       st0, bu0, st1, bu1;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc0, fc0, sc1, fc1;
`endif

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.ADDR_W(5), .DEPTH(2), .LOAD_READY(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .id_wr_addr(id_wr_addr), .ex_flush(ex_flush),
    .fwd_a(fa0), .fwd_b(fb0), .stall(st0), .bubble(bu0)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(sc0), .flush_cnt(fc0)
`endif
  );

  fwd_hazard_ctrl #(.ADDR_W(5), .DEPTH(3), .LOAD_READY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .id_wr_addr(id_wr_addr), .ex_flush(ex_flush),
    .fwd_a(fa1), .fwd_b(fb1), .stall(st1), .bubble(bu1)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  // ctl: 0 normal, 1 assert reset mid-cycle, 2 hold reset through the cycle
  typedef struct { bit v; bit wr; bit ld; bit fl; bit [4:0] rs; bit [4:0] rt; bit [4:0] wa; int ctl; } instr_t;
  typedef struct { bit st; bit bub; int fa; int fb; int sc; int fc; } exp_t;
  typedef struct { bit v; bit wr; bit ld; bit [4:0] a; } ment_t;

  ment_t  hist [2][8];       // hist[c][age]: instruction that entered EX age+1 edges ago
  int     m_fa [2], m_fb [2], m_sc [2], m_fc [2];
  bit     m_bub [2];
  exp_t   q0 [$], q1 [$];
  exp_t   ex0, ex1;
  instr_t prog [$];
  int     checks = 0, errors = 0;

  function automatic int dep(input int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic int lrdy(input int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic instr_t mk(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit wr,
                                input bit ld, input bit [4:0] wa, input bit fl, input int ctl);
    instr_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.wr = wr; i.ld = ld; i.wa = wa; i.fl = fl; i.ctl = ctl;
    return i;
  endfunction

  task automatic m_reset(input int c);
    for (int k = 0; k < 8; k++) begin
      hist[c][k].v = 0; hist[c][k].wr = 0; hist[c][k].ld = 0; hist[c][k].a = 0;
    end
    m_fa[c] = 0; m_fb[c] = 0; m_bub[c] = 0; m_sc[c] = 0; m_fc[c] = 0;
  endtask

  // Youngest producer of r still within forwarding reach; late when it is a load
  // whose data will not yet exist at the stage the consumer would read it from.
  task automatic m_src(input int c, input bit [4:0] r, output int src, output bit late);
    src = 0;
    late = 0;
    if (r != 0) begin
      for (int age = dep(c) - 1; age >= 0; age--) begin
        if (hist[c][age].v && hist[c][age].wr && hist[c][age].a == r) begin
          src  = age + 1;
          late = hist[c][age].ld && (age + 1 < lrdy(c));
        end
      end
    end
  endtask

  task automatic m_cycle(input int c, input instr_t in, input bit in_rst, output exp_t e, output bit st);
    int sa, sb;
    bit la, lb, kill;
    st = 0;
    if (in_rst) m_reset(c);
    e.st = 0; e.bub = m_bub[c]; e.fa = m_fa[c]; e.fb = m_fb[c]; e.sc = m_sc[c]; e.fc = m_fc[c];
    if (!in_rst) begin
      m_src(c, in.rs, sa, la);
      m_src(c, in.rt, sb, lb);
      st = in.v && (la || lb) && !in.fl;
      e.st = st;
      kill = in.fl || st;
      for (int k = 7; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0].v  = kill ? 1'b0 : in.v;
      hist[c][0].wr = kill ? 1'b0 : in.wr;
      hist[c][0].ld = kill ? 1'b0 : in.ld;
      hist[c][0].a  = kill ? 5'd0 : in.wa;
      m_fa[c] = kill ? 0 : sa;
      m_fb[c] = kill ? 0 : sb;
      m_bub[c] = kill;
      if (st && m_sc[c] < 65535) m_sc[c]++;
      if (in.fl && m_fc[c] < 65535) m_fc[c]++;
    end
  endtask

  task automatic step(input instr_t in, output bit any_st);
    exp_t e0, e1;
    bit s0, s1;
    @(posedge clk);
    #1;
    rst_n = (in.ctl == 2) ? 1'b0 : 1'b1;
    id_valid = in.v; id_rs = in.rs; id_rt = in.rt; id_reg_wr = in.wr;
    id_mem_rd = in.ld; id_wr_addr = in.wa; ex_flush = in.fl;
    if (in.ctl == 1) begin
      #1;
      rst_n = 1'b0;
    end
    m_cycle(0, in, !rst_n, e0, s0);
    m_cycle(1, in, !rst_n, e1, s1);
    q0.push_back(e0);
    q1.push_back(e1);
    any_st = s0 || s1;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      ex0 = q0.pop_front();
      cmp("cfg0 stall", {31'd0, st0}, int'(ex0.st));
      cmp("cfg0 bubble", {31'd0, bu0}, int'(ex0.bub));
      cmp("cfg0 fwd_a", {30'd0, fa0}, ex0.fa);
      cmp("cfg0 fwd_b", {30'd0, fb0}, ex0.fb);
`ifdef HAZARD_STATS_EN
      cmp("cfg0 stall_cnt", {16'd0, sc0}, ex0.sc);
      cmp("cfg0 flush_cnt", {16'd0, fc0}, ex0.fc);
`endif
    end
    if (q1.size() > 0) begin
      ex1 = q1.pop_front();
      cmp("cfg1 stall", {31'd0, st1}, int'(ex1.st));
      cmp("cfg1 bubble", {31'd0, bu1}, int'(ex1.bub));
      cmp("cfg1 fwd_a", {30'd0, fa1}, ex1.fa);
      cmp("cfg1 fwd_b", {30'd0, fb1}, ex1.fb);
`ifdef HAZARD_STATS_EN
      cmp("cfg1 stall_cnt", {16'd0, sc1}, ex1.sc);
      cmp("cfg1 flush_cnt", {16'd0, fc1}, ex1.fc);
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected program to complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bit hold;
    int iter;
    m_reset(0);
    m_reset(1);
    // reset held
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2));
    prog.push_back(mk(1, 3, 3, 1, 1, 3, 0, 2));
    // ADD r3 ; SUB r3,r3
    prog.push_back(mk(1, 1, 2, 1, 0, 3, 0, 0));
    prog.push_back(mk(1, 3, 3, 1, 0, 4, 0, 0));
    // ADD r3 ; NOP ; reader r3
    prog.push_back(mk(1, 1, 2, 1, 0, 3, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(1, 3, 1, 1, 0, 6, 0, 0));
    // ADD r3 ; ADD r3 ; reader r3
    prog.push_back(mk(1, 1, 2, 1, 0, 3, 0, 0));
    prog.push_back(mk(1, 2, 1, 1, 0, 3, 0, 0));
    prog.push_back(mk(1, 3, 2, 1, 0, 7, 0, 0));
    // LW r5 ; reader r5 ; NOPs
    prog.push_back(mk(1, 1, 2, 1, 1, 5, 0, 0));
    prog.push_back(mk(1, 5, 5, 1, 0, 8, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // ADD r0 ; reader r0 ; LW r0 ; reader r0
    prog.push_back(mk(1, 1, 2, 1, 0, 0, 0, 0));
    prog.push_back(mk(1, 0, 0, 1, 0, 9, 0, 0));
    prog.push_back(mk(1, 1, 2, 1, 1, 0, 0, 0));
    prog.push_back(mk(1, 0, 0, 1, 0, 9, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // LW r5 ; reader r5 with flush
    prog.push_back(mk(1, 1, 2, 1, 1, 5, 0, 0));
    prog.push_back(mk(1, 5, 5, 1, 0, 8, 1, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // LW r5 ; reader r5 hit by reset in the stall cycle ; ADD r3 ; reader r3
    prog.push_back(mk(1, 1, 2, 1, 1, 5, 0, 0));
    prog.push_back(mk(1, 5, 5, 1, 0, 8, 0, 1));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2));
    prog.push_back(mk(1, 1, 2, 1, 0, 3, 0, 0));
    prog.push_back(mk(1, 3, 4, 1, 0, 6, 0, 0));
    prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // random traffic on a small register set to force collisions
    for (int i = 0; i < 600; i++) begin
      prog.push_back(mk($urandom_range(0, 7) != 0,
                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                        5'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
                        ($urandom_range(0, 99) == 0) ? 1 : 0));
    end

    iter = 0;
    while (prog.size() > 0 && iter < 5000) begin
      step(prog[0], hold);
      if (!hold) void'(prog.pop_front());
      iter++;
    end
    @(negedge clk);
    #1;
    cmp("program completed", prog.size(), 0);
    cmp("scoreboard drained", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and hazard controller for the pipelined CPU; next generation of the two-source EX forwarding unit.
- Keeps its own shadow pipeline of destination records, DEPTH stages deep behind EX. Registers per-operand forwarding selects for the EX stage.
- Detects load-use hazards and drives stall/bubble. Honours branch flush.

Parameters:
- ADDR_W, 5, register address width.
- DEPTH, 2, number of forwarding source stages after EX (1=MEM, 2=WB, ...); range 1..6.
- LOAD_READY, 2, first source stage index at which load data can be forwarded; range 1..DEPTH.
- SEL_W, localparam = clog2(DEPTH+1), width of the forwarding select.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- id_valid, input, 1, ID stage holds a real instruction.
- id_rs, input, ADDR_W, ID source register A.
- id_rt, input, ADDR_W, ID source register B.
- id_reg_wr, input, 1, ID instruction writes the register file.
- id_mem_rd, input, 1, ID instruction is a load.
- id_wr_addr, input, ADDR_W, ID destination register.
- ex_flush, input, 1, branch resolved taken; kill the ID and EX instructions.
- fwd_a, output, SEL_W, EX operand A source: 0=regfile, k=stage k result.
- fwd_b, output, SEL_W, EX operand B source, same encoding.
- stall, output, 1, hold PC and IF/ID this cycle.
- bubble, output, 1, the EX entry loaded at this edge is a NOP.

Behaviour:
- Shadow pipe: entries S[0..DEPTH]; S[0]=EX, S[k]=k stages past EX.
  - Each entry is {valid, wr, ld, addr}. Entry "writes" iff valid && wr && addr != 0.
- Every edge, S[k+1] <= S[k] for k = 0..DEPTH-1. The last entry falls off.
- S[0] load at the edge:
  - ex_flush=1: invalid entry, bubble=1.
  - else stall=1: invalid entry, bubble=1.
  - else: {id_valid, id_reg_wr, id_mem_rd, id_wr_addr}, bubble=0.
- Match (operand r, pre-edge entry S[j], j = 0..DEPTH-1): S[j] writes and addr == r. After the edge that entry sits at stage j+1.
- Forwarding select for r: 0 if r == 0 or no match; else j+1 for the smallest matching j. Youngest producer wins.
- Registered output: at each non-stall, non-flush edge, fwd_a/fwd_b <= select for id_rs/id_rt. On stall or flush edges they are <= 0.
- Load-use: hazard when id_valid and, for id_rs or id_rt, the youngest match S[j] has ld=1 and j+1 < LOAD_READY.
  - stall = hazard && !ex_flush, combinational from current state and ID inputs.
  - Stall persists until the load reaches stage LOAD_READY-1 pre-edge. With defaults: exactly 1 stall cycle for a load directly ahead.
- FSM {RUN, STALL}, registered:
  - RUN -> STALL when stall=1 at the edge.
  - STALL -> RUN when stall=0 at the edge.
  - ex_flush forces RUN.
- Simultaneous events:
  - ex_flush has priority over stall.
  - A hazard on both operands produces one stall, not two.
  - Writes to r0 never forward and never stall.
- Reset (async, immediate): all entries invalid, fwd_a=fwd_b=0, bubble=0, state RUN. stall=0 while rst_n=0. Reset mid-stall drops the stall at once.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on each edge with stall=1.
  - flush_cnt increments on each edge with ex_flush=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Defaults. ADD r3 into ID, then SUB reading rs=r3, rt=r3 next cycle -> after the SUB enters EX, fwd_a=1, fwd_b=1, stall=0.
- ADD r3, then NOP, then reader of r3 -> fwd_a=2. Two ADDs both writing r3, then reader -> fwd_a=1 (youngest wins).
- LW r5, then reader of r5 -> stall=1 for exactly 1 cycle with bubble=1. Reader then enters EX with fwd_a=2. Repeat with DEPTH=3, LOAD_READY=3 -> 2 stall cycles, fwd_a=3.
- ADD r0, then reader of r0 -> fwd_a=0, no stall. LW r0, then reader of r0 -> stall=0.
- LW r5 followed by reader of r5 with ex_flush=1 in the hazard cycle -> stall=0, bubble=1, fwd_a=fwd_b=0. With HAZARD_STATS_EN: flush_cnt=1, stall_cnt=0.
- Assert rst_n=0 during a stall cycle -> stall, bubble, fwd_a, fwd_b all 0 immediately. After release, an ADD r3 ahead of a r3 reader forwards normally (fwd_a=1).
